// File: rtl/reflex_game_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// reflex_pkg
// Shared definitions for the reflex game sequencer: action codes, operation
// codes, the FSM state type and the default per-level action sequences.
// No ports (package).
// ---------------------------------------------------------------------------
package reflex_pkg;

    // Action codes, matching btn_pulse bit positions
    localparam logic [1:0] UP    = 2'd0;
    localparam logic [1:0] DOWN  = 2'd1;
    localparam logic [1:0] LEFT  = 2'd2;
    localparam logic [1:0] RIGHT = 2'd3;

    // op_code values that are not a button code
    localparam logic [2:0] NONE  = 3'd4;
    localparam logic [2:0] MULTI = 3'd7;

    localparam int TMR_W = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP,
        ST_WON,
        ST_LOST
    } game_state_e;

    // Default action tables, 15 actions of 2 bits each, action 0 in [1:0]
    localparam logic [29:0] SEQ_L1_DEF = 30'h1B1B_1B1B;
    localparam logic [29:0] SEQ_L2_DEF = 30'h2D2D_2D2D;
    localparam logic [29:0] SEQ_L3_DEF = 30'h39C6_E4B1;

    // Action idx of a packed sequence. Zero-extended to 32 bits so that the
    // part-select stays in range for every 4-bit index.
    function automatic logic [1:0] seq_action(input logic [29:0] seq,
                                              input logic [3:0]  idx);
        logic [31:0] ext;
        ext = {2'b00, seq};
        return ext[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/reflex_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// reflex_game_if
// Player/display side signals of the reflex game controller.
//   master : the board side (switch, ms strobe, debounced buttons) which
//            drives the inputs and consumes the display/status outputs.
//   slave  : the game controller itself.
// ---------------------------------------------------------------------------
interface reflex_game_if;
    logic       start_sw;
    logic       tick_ms;
    logic [3:0] btn_pulse;
    logic [1:0] level;
    logic [3:0] action_idx;
    logic [1:0] action_code;
    logic [2:0] op_code;
    logic       judge_ok;
    logic       judge_bad;
    logic [1:0] wrong_cnt;
    logic [2:0] levels_won;
    logic       game_over;
    logic       game_won;

    modport master (
        output start_sw, tick_ms, btn_pulse,
        input  level, action_idx, action_code, op_code, judge_ok, judge_bad,
               wrong_cnt, levels_won, game_over, game_won
    );

    modport slave (
        input  start_sw, tick_ms, btn_pulse,
        output level, action_idx, action_code, op_code, judge_ok, judge_bad,
               wrong_cnt, levels_won, game_over, game_won
    );
endinterface

// File: rtl/reflex_game_ctrl_ms_window_timer.sv
// ---------------------------------------------------------------------------
// ms_window_timer
// Millisecond counter for response windows and the inter-level pause.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : force count to 0 (wins over counting)
//   enable     : count tick_ms strobes while high
//   tick_ms    : 1 ms strobe
//   limit      : window length in ms
//   count      : elapsed ms in the current window
//   expire     : combinational pulse on the tick that completes the window
// ---------------------------------------------------------------------------
module ms_window_timer
    import reflex_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             tick_ms,
    input  logic [TMR_W-1:0] limit,
    output logic [TMR_W-1:0] count,
    output logic             expire
);
    logic [TMR_W-1:0] count_q, count_d;

    assign expire = enable && tick_ms && (count_q == limit - TMR_W'(1));
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && tick_ms) begin
            count_d = count_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/reflex_game_ctrl.sv
// ---------------------------------------------------------------------------
// reflex_game_ctrl
// Synchronous game sequencer: three levels of ACTS_PER_LEVEL actions, each
// with a timed response window, judged against debounced button pulses.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : reflex_game_if.slave
//                in : start_sw (enable switch), tick_ms, btn_pulse[3:0]
//                out: level, action_idx, action_code, op_code, judge_ok,
//                     judge_bad, wrong_cnt, levels_won, game_over, game_won
// All outputs are registered.
// ---------------------------------------------------------------------------
module reflex_game_ctrl
    import reflex_pkg::*;
#(
    parameter int          ACTS_PER_LEVEL = 15,
    parameter int          WIN_L1_MS      = 5000,
    parameter int          WIN_L2_MS      = 4000,
    parameter int          WIN_L3_MS      = 3000,
    parameter int          LEVEL_GAP_MS   = 1000,
    parameter int          MAX_WRONG      = 3,
    parameter logic [29:0] SEQ_L1         = SEQ_L1_DEF,
    parameter logic [29:0] SEQ_L2         = SEQ_L2_DEF,
    parameter logic [29:0] SEQ_L3         = SEQ_L3_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    reflex_game_if.slave bus
);
    localparam logic [3:0] LAST_IDX  = 4'(ACTS_PER_LEVEL - 1);
    localparam logic [2:0] MAX_W     = 3'(MAX_WRONG);

    game_state_e state_q, state_d;
    logic [1:0]  level_q, level_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:0]  code_q, code_d;
    logic [2:0]  op_q, op_d;
    logic        ok_q, ok_d;
    logic        bad_q, bad_d;
    logic [1:0]  wrong_q, wrong_d;
    logic [2:0]  won_q, won_d;
    logic        over_q, over_d;
    logic        gwon_q, gwon_d;
    logic        start_prev_q;

    logic             tmr_clear, tmr_enable, tmr_expire;
    logic [TMR_W-1:0] tmr_limit;
    logic [TMR_W-1:0] unused_tmr_count;

    logic       press, multi, judged;
    logic [1:0] btn_code;
    logic [3:0] next_idx;

    function automatic logic [1:0] code_for(input logic [1:0] lvl,
                                            input logic [3:0] idx);
        case (lvl)
            2'd1:    return seq_action(SEQ_L1, idx);
            2'd2:    return seq_action(SEQ_L2, idx);
            default: return seq_action(SEQ_L3, idx);
        endcase
    endfunction

    // Only expire is needed here; count is kept on the timer for observability.
    ms_window_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .tick_ms (bus.tick_ms),
        .limit   (tmr_limit),
        .count   (unused_tmr_count),
        .expire  (tmr_expire)
    );

    always_comb begin
        tmr_limit = TMR_W'(LEVEL_GAP_MS);
        if (state_q == ST_PLAY) begin
            case (level_q)
                2'd1:    tmr_limit = TMR_W'(WIN_L1_MS);
                2'd2:    tmr_limit = TMR_W'(WIN_L2_MS);
                default: tmr_limit = TMR_W'(WIN_L3_MS);
            endcase
        end
    end

    always_comb begin
        press    = |bus.btn_pulse;
        multi    = press && !$onehot(bus.btn_pulse);
        btn_code = 2'd0;
        case (bus.btn_pulse)
            4'b0010: btn_code = 2'd1;
            4'b0100: btn_code = 2'd2;
            4'b1000: btn_code = 2'd3;
            default: btn_code = 2'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        idx_d    = idx_q;
        code_d   = code_q;
        op_d     = op_q;
        ok_d     = 1'b0;
        bad_d    = 1'b0;
        wrong_d  = wrong_q;
        won_d    = won_q;
        judged   = 1'b0;
        // idx parks on the last action once a level ends or the game is lost
        next_idx = (idx_q == LAST_IDX) ? idx_q : idx_q + 4'd1;

        if (!bus.start_sw) begin
            state_d = ST_IDLE;
            level_d = 2'd0;
            idx_d   = 4'd0;
            code_d  = 2'd0;
            op_d    = NONE;
            wrong_d = 2'd0;
            won_d   = 3'b000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!start_prev_q) begin
                        state_d = ST_PLAY;
                        level_d = 2'd1;
                        idx_d   = 4'd0;
                        code_d  = code_for(2'd1, 4'd0);
                        wrong_d = 2'd0;
                        won_d   = 3'b000;
                    end
                end
                ST_PLAY: begin
                    // A press in the expiring cycle is judged; the timeout is dropped.
                    if (press || tmr_expire) begin
                        judged = 1'b1;
                        if (press && !multi && btn_code == code_q) begin
                            ok_d = 1'b1;
                            op_d = {1'b0, btn_code};
                        end else begin
                            bad_d = 1'b1;
                            op_d  = !press ? NONE : (multi ? MULTI : {1'b0, btn_code});
                        end
                        idx_d  = next_idx;
                        code_d = code_for(level_q, next_idx);
                        // Losing takes priority over completing the level
                        if (bad_d && ({1'b0, wrong_q} + 3'd1 >= MAX_W)) begin
                            wrong_d = MAX_W[1:0];
                            state_d = ST_LOST;
                        end else begin
                            if (bad_d) begin
                                wrong_d = wrong_q + 2'd1;
                            end
                            if (idx_q == LAST_IDX) begin
                                won_d   = {won_q[1:0], 1'b1};
                                state_d = (level_q == 2'd3) ? ST_WON : ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (tmr_expire) begin
                        state_d = ST_PLAY;
                        level_d = level_q + 2'd1;
                        idx_d   = 4'd0;
                        code_d  = code_for(level_q + 2'd1, 4'd0);
                    end
                end
                default: ;
            endcase
        end

        over_d     = (state_d == ST_LOST);
        gwon_d     = (state_d == ST_WON);
        tmr_enable = (state_q == ST_PLAY) || (state_q == ST_GAP);
        tmr_clear  = judged || (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        // Tracking the switch during reset means a switch left high through
        // reset does not count as a new start edge.
        start_prev_q <= bus.start_sw;
        if (!rst_n) begin
            state_q <= ST_IDLE;
            level_q <= 2'd0;
            idx_q   <= 4'd0;
            code_q  <= 2'd0;
            op_q    <= NONE;
            ok_q    <= 1'b0;
            bad_q   <= 1'b0;
            wrong_q <= 2'd0;
            won_q   <= 3'b000;
            over_q  <= 1'b0;
            gwon_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            op_q    <= op_d;
            ok_q    <= ok_d;
            bad_q   <= bad_d;
            wrong_q <= wrong_d;
            won_q   <= won_d;
            over_q  <= over_d;
            gwon_q  <= gwon_d;
        end
    end

    assign bus.level       = level_q;
    assign bus.action_idx  = idx_q;
    assign bus.action_code = code_q;
    assign bus.op_code     = op_q;
    assign bus.judge_ok    = ok_q;
    assign bus.judge_bad   = bad_q;
    assign bus.wrong_cnt   = wrong_q;
    assign bus.levels_won  = won_q;
    assign bus.game_over   = over_q;
    assign bus.game_won    = gwon_q;
endmodule

// File: doc/reflex_game_ctrl.md
# reflex_game_ctrl

Single-clock game sequencer for the reflex game. It replaces the per-level multi-clock counters and the asynchronous level/wrong/win logic with one synchronous FSM. It steps three levels of 15 actions each and times each action's response window from a 1 ms strobe. It judges debounced button pulses, accumulates misses and drives the level, action, operation, wrong-count and win/lose status consumed by the 7-segment and LED display blocks.

## Interface
Parameters:
- ACTS_PER_LEVEL, 15: actions per level.
- WIN_L1_MS / WIN_L2_MS / WIN_L3_MS, 5000 / 4000 / 3000: response window per action, in ms.
- LEVEL_GAP_MS, 1000: pause between levels.
- MAX_WRONG, 3: misses that end the game.
- SEQ_L1 / SEQ_L2 / SEQ_L3, 30 bits each: action sequences at 2 bits per action; action i is SEQ[2i+:2]; defaults come from the package.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset, synchronous, active-low.
- start_sw, in, 1: game enable switch, level-sensitive.
- tick_ms, in, 1: one-cycle strobe every 1 ms.
- btn_pulse, in, 4: debounced one-cycle press pulses. Bit k means action code k: 0 up, 1 down, 2 left, 3 right.
- level, out, 2: 0 = idle, 1..3 = current level.
- action_idx, out, 4: index within the level, 0..14.
- action_code, out, 2: action currently shown.
- op_code, out, 3: last player operation. 0..3 = button code, 4 = none/timeout, 7 = multi-press.
- judge_ok, out, 1: one-cycle pulse on a correct press.
- judge_bad, out, 1: one-cycle pulse on a miss.
- wrong_cnt, out, 2: accumulated misses, saturating at MAX_WRONG.
- levels_won, out, 3: thermometer code; bit n set when level n+1 is cleared. Drives the win LEDs.
- game_over, out, 1: set in LOST.
- game_won, out, 1: set in WON.

## Operation
- States: IDLE, PLAY, GAP, WON, LOST.
- Every output is registered.
- Reset values: level 0, action_idx 0, action_code 0, op_code 4, judge_ok 0, judge_bad 0, wrong_cnt 0, levels_won 0, game_over 0, game_won 0; state IDLE.
- IDLE -> PLAY on a rising edge of start_sw, using a registered previous value of start_sw. On entry: level 1, idx 0, wrong_cnt 0, levels_won 0, timer 0.
- start_sw low in any state -> IDLE next cycle, and all outputs return to their reset values. This is the abort.
- PLAY, judging:
  - Exactly one btn_pulse bit set and it equals action_code -> judge_ok.
  - Any other nonzero btn_pulse -> judge_bad. Record op_code = 7 if more than one bit is set, otherwise the bit index.
  - Timer reaching the level window with no press -> judge_bad, op_code 4.
- After every judgement: timer cleared and idx incremented. If idx was 14, the level is complete.
- Miss accounting: on judge_bad, wrong_cnt increments. When it reaches MAX_WRONG -> LOST. This takes priority over level completion in the same cycle.
- Level complete, levels 1–2: set levels_won bit, go to GAP. After LEVEL_GAP_MS -> PLAY with level+1, idx 0. wrong_cnt persists across levels.
- Level complete, level 3: set levels_won[2], go to WON.
- btn_pulse is ignored in IDLE, GAP, WON and LOST.
- WON and LOST hold all outputs until start_sw falls.

## Timing
- Timer: 13-bit ms counter, advancing only on tick_ms in PLAY and GAP. The window expires on the cycle where tick_ms = 1 and count = WIN − 1.
- Latency: press or timeout in cycle t -> judge pulse, op_code, wrong_cnt, action_idx and action_code all update at t+1.
- A press and window expiry in the same cycle: the press is judged and the timeout is dropped.
- Start edge in cycle t -> level 1 and action_code = SEQ_L1[1:0] visible at t+1.
- rst_n low overrides start_sw and all events, including mid-level.

## Structure
- Package reflex_pkg holds:
  - action code constants UP/DOWN/LEFT/RIGHT;
  - the state enum;
  - op_code constants NONE = 4 and MULTI = 7;
  - default SEQ_L1..L3 (30'h… values derived from the existing per-level action tables).
- Sub-module ms_window_timer: clear, enable, tick_ms and limit in; 13-bit count and expire pulse out.
- The FSM and judge logic stay in reflex_game_ctrl.
- Bench setting: WIN_Lx = 4/3/2 ms and LEVEL_GAP_MS = 2, with a tick_ms strobe every 10 cycles.

## Test plan
- Perfect game: rise start_sw, then press the correct button each action -> 45 judge_ok pulses; levels_won reaches 3'b111; game_won = 1; wrong_cnt = 0.
- Timeouts: start, no presses -> judge_bad every 4 ms. After the 3rd miss: game_over = 1, level = 1, action_idx = 3, op_code = 4.
- Multi-press and wrong button: btn_pulse 4'b0011, then a single wrong code -> op_code 7, then the pressed code. wrong_cnt goes 1 then 2, and idx advances each time.
- Press/expiry collision: press the correct button exactly on the expiring tick -> judge_ok only, wrong_cnt unchanged.
- Level transition: finish level 1 with 1 miss -> GAP for 2 ms with level still 1. Then level = 2, idx = 0, wrong_cnt = 1, levels_won = 3'b001.
- Abort and reset: drop start_sw mid-level 2 -> all outputs at reset values next cycle. Assert rst_n low mid-PLAY with start_sw high -> reset values, and no restart until a new start_sw rising edge.
